// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types for the SPI RAM arbiter: FSM states, transfer types and master IDs.
package spi_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    TYPE_RD = 1'b0,
    TYPE_WR = 1'b1
  } xfer_type_t;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-requester grant: a lone request wins; a tie goes to the master not served last,
// or always to M0 when fixed priority is selected.
module rr_arb2
  import spi_ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       gnt
);

  always_comb begin
    gnt = MID_M0;
    case (req)
      2'b10:   gnt = MID_M1;
      2'b11:   gnt = fixed_prio ? MID_M0 : ~last;
      default: gnt = MID_M0;
    endcase
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one MappedSPIRAM port between the CPU (M0) and the DMA/boot loader (M1),
// serialising one RAM transaction at a time with a hung-RAM timeout.
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] TO_RDATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m0_wdata,
  input  logic [7:0]  m1_wdata,
  input  logic        m0_rd,
  input  logic        m1_rd,
  input  logic        m0_wr,
  input  logic        m1_wr,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_rbusy,
  output logic        m1_rbusy,
  output logic        m0_wbusy,
  output logic        m1_wbusy,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic        ram_rbusy,
  input  logic        ram_wbusy,
  input  logic [31:0] ram_rdata,
  output logic        timeout_err
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  arb_state_t  state, state_nx;
  logic [1:0]  rd_in, wr_in, strobe, accept, pending, req;
  logic [15:0] addr_in   [2];
  logic [7:0]  wdata_in  [2];
  logic [15:0] addr_lat  [2];
  logic [7:0]  wdata_lat [2];
  xfer_type_t  type_lat  [2];
  logic        gnt_q, arb_gnt, last_grant, abort, set_abort, in_done, timeout_hit;
  logic [31:0] timer, rdata_nx;

  assign rd_in       = {m1_rd, m0_rd};
  assign wr_in       = {m1_wr, m0_wr};
  assign strobe      = rd_in | wr_in;
  assign addr_in[0]  = m0_addr;
  assign addr_in[1]  = m1_addr;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;
  assign in_done     = (state == ST_DONE);
  assign timeout_hit = TO_EN && (timer == TO_LAST);
  assign rdata_nx    = abort ? TO_RDATA : ram_rdata;

  // A strobe is taken when the master is idle, or when its own transaction retires this cycle.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++)
      accept[i] = strobe[i] & (~pending[i] | (in_done & (gnt_q == 1'(i))));
  end

  assign req = pending | accept;

  assign m0_rbusy = m0_rd | (pending[0] & (type_lat[0] == TYPE_RD));
  assign m0_wbusy = m0_wr | (pending[0] & (type_lat[0] == TYPE_WR));
  assign m1_rbusy = m1_rd | (pending[1] & (type_lat[1] == TYPE_RD));
  assign m1_wbusy = m1_wr | (pending[1] & (type_lat[1] == TYPE_WR));

  rr_arb2 u_arb (
    .req        (req),
    .last       (last_grant),
    .fixed_prio (FIXED_PRIO),
    .gnt        (arb_gnt)
  );

  always_comb begin
    state_nx  = state;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    set_abort = 1'b0;
    unique case (state)
      ST_IDLE:  if (|req) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        ram_rd    = (type_lat[gnt_q] == TYPE_RD);
        ram_wr    = (type_lat[gnt_q] == TYPE_WR);
        ram_addr  = addr_lat[gnt_q];
        ram_wdata = wdata_lat[gnt_q];
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        if (!ram_rbusy && !ram_wbusy) begin
          state_nx = ST_DONE;
        end else if (timeout_hit) begin
          state_nx  = ST_DONE;
          set_abort = 1'b1;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      last_grant  <= MID_M1;
      gnt_q       <= MID_M0;
      abort       <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && |req) gnt_q <= arb_gnt;
      if (state == ST_ISSUE) begin
        timer <= '0;
        abort <= 1'b0;
      end
      if (state == ST_WAIT) begin
        timer <= sat_inc(timer);
        if (set_abort) begin
          abort       <= 1'b1;
          timeout_err <= 1'b1;
        end
      end
      if (in_done) begin
        last_grant <= gnt_q;
        if (type_lat[gnt_q] == TYPE_RD) begin
          if (gnt_q == MID_M0) m0_rdata <= rdata_nx;
          else                 m1_rdata <= rdata_nx;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (accept[i])                          pending[i] <= 1'b1;
        else if (in_done && gnt_q == 1'(i))     pending[i] <= 1'b0;
      end
    end
  end

  // Request latches are data only; pending qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) begin
        type_lat[i]  <= wr_in[i] ? TYPE_WR : TYPE_RD;
        addr_lat[i]  <= addr_in[i];
        wdata_lat[i] <= wdata_in[i];
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_proto
    a_no_restrobe: assert property (@(posedge clk) disable iff (rst)
      !(strobe[i] && pending[i] && !(in_done && gnt_q == 1'(i))));
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: transaction-timeline model checked every cycle plus directed literals.
module tb_spi_ram_arbiter;

  localparam int          T    = 16;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic        m0_rd = 0, m1_rd = 0, m0_wr = 0, m1_wr = 0;
  logic [31:0] m0_rdata, m1_rdata, ram_rdata = '0;
  logic        m0_rbusy, m1_rbusy, m0_wbusy, m1_wbusy, ram_rd, ram_wr, timeout_err;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_rbusy, ram_wbusy;

  // fixed-priority instance
  logic [15:0] f_m0_addr = '0, f_m1_addr = '0, f_ram_addr;
  logic        f_m0_wr = 0, f_m1_wr = 0;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_m0_rbusy, f_m1_rbusy, f_m0_wbusy, f_m1_wbusy, f_ram_rd, f_ram_wr, f_timeout_err;
  logic [7:0]  f_ram_wdata;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rd(m0_rd), .m1_rd(m1_rd), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rbusy(m0_rbusy), .m1_rbusy(m1_rbusy), .m0_wbusy(m0_wbusy), .m1_wbusy(m1_wbusy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy), .ram_rdata(ram_rdata),
    .timeout_err(timeout_err)
  );

  spi_ram_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(T)) u_fp (
    .clk(clk), .rst(rst),
    .m0_addr(f_m0_addr), .m1_addr(f_m1_addr), .m0_wdata(8'h00), .m1_wdata(8'h00),
    .m0_rd(1'b0), .m1_rd(1'b0), .m0_wr(f_m0_wr), .m1_wr(f_m1_wr),
    .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
    .m0_rbusy(f_m0_rbusy), .m1_rbusy(f_m1_rbusy), .m0_wbusy(f_m0_wbusy), .m1_wbusy(f_m1_wbusy),
    .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rd(f_ram_rd), .ram_wr(f_ram_wr),
    .ram_rbusy(1'b0), .ram_wbusy(1'b0), .ram_rdata(32'h0),
    .timeout_err(f_timeout_err)
  );

  // RAM: busy for ram_len cycles counting the strobe cycle; ram_hang holds rbusy.
  int ram_len = 1;
  bit ram_hang = 0;
  int rcnt = 0, wcnt = 0;
  always @(posedge clk) begin
    if (ram_rd) rcnt <= ram_len - 1; else if (rcnt > 0) rcnt <= rcnt - 1;
    if (ram_wr) wcnt <= ram_len - 1; else if (wcnt > 0) wcnt <= wcnt - 1;
  end
  assign ram_rbusy = ram_hang | ram_rd | (rcnt > 0);
  assign ram_wbusy = ram_wr | (wcnt > 0);

  int nchk = 0, nfail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending set per master, and a current transaction described by its timeline
  // (grant cycle -> issue cycle -> first wait cycle -> retire cycle).
  bit          chk_on = 0;
  int          cyc = 0;
  bit          mp [2];
  bit          mt [2];
  logic [15:0] ma [2];
  logic [7:0]  mw [2];
  logic [31:0] mrd [2];
  int          own = -1, t_issue = 0, t_wait0 = 0, t_done = -1;
  bit          mab = 0, mlast = 1, mto = 0;
  logic [15:0] glog [$];
  logic [15:0] fq [$];
  int          nrd = 0, nwr = 0;

  always @(negedge clk) begin
    bit rdv [2], wrv [2], stb [2], acc [2];
    bit done_now, exp_ird, exp_iwr, r0, r1;
    rdv[0] = m0_rd; rdv[1] = m1_rd; wrv[0] = m0_wr; wrv[1] = m1_wr;
    if (ram_rd) nrd++;
    if (ram_wr) nwr++;
    if (ram_rd | ram_wr) glog.push_back(ram_addr);
    if (f_ram_rd | f_ram_wr) fq.push_back(f_ram_addr);
    if (chk_on) begin
      chk("m0_rbusy", m0_rbusy, rdv[0] | (mp[0] & !mt[0]));
      chk("m0_wbusy", m0_wbusy, wrv[0] | (mp[0] & mt[0]));
      chk("m1_rbusy", m1_rbusy, rdv[1] | (mp[1] & !mt[1]));
      chk("m1_wbusy", m1_wbusy, wrv[1] | (mp[1] & mt[1]));
      exp_ird = 0; exp_iwr = 0;
      if (own >= 0 && cyc == t_issue) begin exp_ird = !mt[own]; exp_iwr = mt[own]; end
      chk("ram_rd", ram_rd, exp_ird);
      chk("ram_wr", ram_wr, exp_iwr);
      if (exp_ird | exp_iwr) begin
        chk("ram_addr", ram_addr, ma[own]);
        chk("ram_wdata", ram_wdata, mw[own]);
      end
      chk("m0_rdata", m0_rdata, mrd[0]);
      chk("m1_rdata", m1_rdata, mrd[1]);
      chk("timeout_err", timeout_err, mto);
    end
    if (rst) begin
      mp[0] = 0; mp[1] = 0; own = -1; t_done = -1; mab = 0; mlast = 1; mto = 0;
      mrd[0] = '0; mrd[1] = '0;
    end else begin
      done_now = (own >= 0) && (cyc == t_done);
      for (int i = 0; i < 2; i++) begin
        stb[i] = rdv[i] | wrv[i];
        acc[i] = stb[i] && (!mp[i] || (done_now && own == i));
      end
      if (own < 0) begin
        r0 = mp[0] | stb[0];
        r1 = mp[1] | stb[1];
        if (r0 || r1) begin
          own = (r0 && r1) ? (mlast ? 0 : 1) : (r1 ? 1 : 0);
          t_issue = cyc + 1; t_wait0 = cyc + 2; t_done = -1;
        end
      end else if (done_now) begin
        if (!mt[own]) mrd[own] = mab ? DEAD : ram_rdata;
        mp[own] = 0; mlast = (own == 1); own = -1;
      end else if (t_done < 0 && cyc >= t_wait0) begin
        if (!ram_rbusy && !ram_wbusy) begin t_done = cyc + 1; mab = 0; end
        else if (cyc - t_wait0 == T - 1) begin t_done = cyc + 1; mab = 1; mto = 1; end
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          mp[i] = 1; mt[i] = wrv[i];
          ma[i] = (i == 1) ? m1_addr : m0_addr;
          mw[i] = (i == 1) ? m1_wdata : m0_wdata;
        end
      end
    end
    cyc++;
  end

  function automatic bit mbusy(input int m);
    return (m == 1) ? (m1_rbusy | m1_wbusy) : (m0_rbusy | m0_wbusy);
  endfunction

  task automatic set_in(input int m, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
    if (m == 1) begin m1_rd = r; m1_wr = w; m1_addr = a; m1_wdata = d; end
    else        begin m0_rd = r; m0_wr = w; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic pulse(input bit r0, w0, r1, w1, input logic [15:0] a0, a1, input logic [7:0] d0, d1);
    @(posedge clk); #1;
    set_in(0, r0, w0, a0, d0); set_in(1, r1, w1, a1, d1);
    @(posedge clk); #1;
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
  endtask

  // Strobe one master and count the cycles its busy stays high, strobe cycle included.
  task automatic xfer_len(input int m, input bit r, input bit w, input logic [15:0] a,
                          input logic [7:0] d, output int n);
    @(posedge clk); #1;
    set_in(m, r, w, a, d);
    n = 0;
    @(negedge clk); if (mbusy(m)) n++;
    @(posedge clk); #1;
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!mbusy(m)) break;
      n++;
    end
  endtask

  task automatic wait_quiet(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (own < 0 && !mp[0] && !mp[1] && !mbusy(0) && !mbusy(1)) begin ok = 1; break; end
    end
    chk("wait_quiet", ok, 1);
  endtask

  logic [15:0] e2 [5] = '{16'h0A00, 16'h0B00, 16'h0A01, 16'h0B02, 16'h0A02};
  logic [15:0] e3 [6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'h0004, 16'h0005};

  task automatic fpulse(input bit w0, w1, input logic [15:0] a0, a1);
    @(posedge clk); #1;
    f_m0_wr = w0; f_m1_wr = w1; f_m0_addr = a0; f_m1_addr = a1;
    @(posedge clk); #1;
    f_m0_wr = 0; f_m1_wr = 0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    int n, r0c, w0c, found;
    repeat (3) @(posedge clk);
    #1 rst = 0; chk_on = 1;
    @(negedge clk);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_strobes", {ram_rd, ram_wr, m0_rbusy, m1_wbusy}, 0);

    // simultaneous writes, two tie rounds separated by a lone M0 write
    ram_len = 2; glog.delete(); w0c = nwr;
    pulse(0, 1, 0, 1, 16'h0A00, 16'h0B00, 8'h11, 8'h22); wait_quiet(100);
    pulse(0, 1, 0, 0, 16'h0A01, 16'h0000, 8'h33, 8'h00); wait_quiet(100);
    pulse(0, 1, 0, 1, 16'h0A02, 16'h0B02, 8'h44, 8'h55); wait_quiet(100);
    chk("t2_wr_pulses", nwr - w0c, 5);
    chk("t2_log_size", glog.size(), 5);
    if (glog.size() == 5) for (int i = 0; i < 5; i++) chk("t2_order", glog[i], e2[i]);

    // single read, RAM busy 5 cycles
    ram_len = 5; ram_rdata = 32'h1234_5678; r0c = nrd;
    xfer_len(0, 1, 0, 16'h0010, 8'h00, n);
    chk("t1_busy_cycles", n, 8);
    wait_quiet(50);
    chk("t1_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_rd_pulses", nrd - r0c, 1);

    // new strobe from the granted master in its DONE cycle
    ram_len = 3; ram_rdata = 32'hCAFE_0001; glog.delete(); found = 0;
    pulse(1, 0, 0, 0, 16'h0C00, 16'h0000, 8'h00, 8'h00);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (own == 0 && t_done >= 0) begin found = 1; break; end
    end
    chk("t7_reached_done", found, 1);
    @(posedge clk); #1; set_in(0, 0, 1, 16'h0C01, 8'h77);
    @(posedge clk); #1; m0_wr = 0;
    wait_quiet(50);
    chk("t7_log_size", glog.size(), 2);
    if (glog.size() == 2) chk("t7_second", glog[1], 16'h0C01);
    chk("t7_rdata", m0_rdata, 32'hCAFE_0001);

    // hung RAM
    ram_hang = 1;
    xfer_len(1, 1, 0, 16'h0D00, 8'h00, n);
    chk("t4_busy_cycles", n, 19);
    wait_quiet(50); ram_hang = 0;
    chk("t4_rdata", m1_rdata, DEAD);
    chk("t4_timeout_err", timeout_err, 1);
    ram_len = 1;
    xfer_len(0, 0, 1, 16'h0D01, 8'h99, n);
    wait_quiet(50);
    chk("t4_err_sticky", timeout_err, 1);

    // read and write together: write wins
    ram_len = 2; r0c = nrd; w0c = nwr;
    @(posedge clk); #1; set_in(0, 1, 1, 16'h0F00, 8'h5A);
    @(negedge clk); chk("t6_wbusy", m0_wbusy, 1);
    @(posedge clk); #1; m0_rd = 0; m0_wr = 0;
    wait_quiet(50);
    chk("t6_rd_pulses", nrd - r0c, 0);
    chk("t6_wr_pulses", nwr - w0c, 1);

    // reset during WAIT, with an M1 strobe in the reset cycle
    ram_len = 10;
    pulse(1, 0, 0, 0, 16'h0E00, 16'h0000, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1; set_in(1, 1, 0, 16'h0E10, 8'h00);
    @(posedge clk); #1 rst = 0; m1_rd = 0;
    @(negedge clk);
    chk("t5_busy", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 0);
    chk("t5_strobes", {ram_rd, ram_wr}, 0);
    chk("t5_timeout_err", timeout_err, 0);
    ram_rdata = 32'h0BAD_F00D;
    xfer_len(1, 1, 0, 16'h0E20, 8'h00, n);
    wait_quiet(80);
    chk("t5_m1_rdata", m1_rdata, 32'h0BAD_F00D);

    // fixed priority: M0 wins every tie even when it was served last
    fq.delete();
    fpulse(1, 0, 16'h0001, 16'h0000);
    fpulse(1, 1, 16'h0002, 16'h0003);
    fpulse(1, 0, 16'h0006, 16'h0000);
    fpulse(1, 1, 16'h0004, 16'h0005);
    chk("t3_log_size", fq.size(), 6);
    if (fq.size() == 6) for (int i = 0; i < 6; i++) chk("t3_order", fq[i], e3[i]);
    chk("t3_idle", {f_m0_rbusy, f_m0_wbusy, f_m1_rbusy, f_m1_wbusy, f_timeout_err}, 0);
    chk("t3_rdata", f_m0_rdata | f_m1_rdata | {24'h0, f_ram_wdata}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
